cam_match_array: RTL and testbench
==================================

// Module: cam_match_array
// PURPOSE
//  Storage and compare stage feeding the CAM priority encoder. Holds DEPTH entries of
//  DATA_WIDTH bits, each with a valid bit. Compares a search key against every valid
//  entry in parallel and emits a registered one-hot-or-more match vector.
//  match_lines connects directly to the encoder's cam_data_in; match_valid qualifies
//  the encoder's cam_enable.
// PARAMETERS
//  ADDR_WIDTH  8                 entry address width
//  DEPTH       (1 << ADDR_WIDTH) number of entries; must equal the encoder's DEPTH
//  DATA_WIDTH  16                width of stored entries and search key
// PORTS
//  clk            in   1              clock, all logic on posedge
//  reset          in   1              synchronous, active-high
//  flush_req      in   1              start a sweep that clears all entries
//  wr_enable      in   1              write strobe
//  wr_addr        in   ADDR_WIDTH     entry to write
//  wr_data        in   DATA_WIDTH     data stored when wr_valid=1
//  wr_valid       in   1              1: store wr_data and set valid; 0: invalidate entry
//  search_enable  in   1              launch a compare this cycle
//  search_data    in   DATA_WIDTH     search key
//  match_lines    out  DEPTH          bit i = entry i valid and equal to key (registered)
//  match_valid    out  1              match_lines belongs to a search launched last cycle
//  busy           out  1              flush sweep in progress
//  entry_count    out  ADDR_WIDTH+1   number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Data array has no reset network. Valid bits and the data array are cleared only
//    by the sweep FSM.
//  - FSM states are IDLE and FLUSH.
//    - reset=1: next state FLUSH, sweep pointer 0, match_lines 0, match_valid 0,
//      entry_count 0, busy 1 from the cycle after reset.
//    - IDLE -> FLUSH: on flush_req; pointer loads 0.
//    - FLUSH: each cycle clears data[ptr] to 0 and valid[ptr] to 0, then ptr++.
//      After ptr = DEPTH-1 is cleared, returns to IDLE.
//    - Sweep takes exactly DEPTH cycles. busy=1 for all of them.
//    - flush_req during FLUSH is ignored; the sweep does not restart.
//  - While busy:
//    - wr_enable and search_enable are ignored.
//    - match_valid=0 and match_lines=0.
//    - entry_count is forced to 0 on FLUSH entry.
//  - Write (IDLE, wr_enable=1) takes effect at the clock edge:
//    - wr_valid=1: data[wr_addr] <= wr_data, valid <= 1.
//    - wr_valid=0: valid <= 0; data is unchanged.
//  - entry_count update:
//    - +1 when an invalid slot becomes valid.
//    - -1 when a valid slot is invalidated.
//    - unchanged when a valid slot is overwritten or an invalid slot is invalidated.
//    - Never wraps: range 0..DEPTH.
//  - Search (IDLE, search_enable=1):
//    - Latency 1: the next cycle has match_valid=1 and match_lines[i] = valid[i] &&
//      (data[i] == search_data).
//    - Otherwise the next cycle has match_valid=0 and match_lines=0.
//  - Write and search in the same cycle: the compare uses pre-write contents.
//    The new entry is visible to searches launched from the next cycle.
//  - flush_req together with a write or search in IDLE:
//    - The flush wins; the write and search are dropped.
//    - match_valid=0 on the next cycle.
//  - Multiple entries may match. Priority resolution belongs to the downstream
//    encoder, not this block.
//  - reset mid-sweep or mid-search: the sweep restarts from pointer 0, and the
//    next-cycle match_valid is 0.
// TESTING
//  1. Reset, hold idle -> busy=1 for exactly DEPTH cycles (256), then 0;
//     entry_count=0; match_valid=0 throughout.
//  2. Write 0xBEEF@3, 0xBEEF@200, 0x1234@7, then search 0xBEEF -> next cycle
//     match_valid=1, match_lines bits 3 and 200 set only; entry_count=3.
//  3. Invalidate @3, then search 0xBEEF -> only bit 200 set; entry_count=2.
//     Overwrite @200 with 0x0001 -> count stays 2.
//  4. Same cycle: write 0xCAFE@9 and search 0xCAFE -> bit 9 clear.
//     Search 0xCAFE again -> bit 9 set.
//  5. Fill all 256 entries -> entry_count=256 with no wrap.
//     Assert flush_req with a search -> match_valid=0, busy 256 cycles, count 0,
//     all-zero key search afterwards returns match_lines=0.
//  6. Assert reset at sweep cycle 100 -> sweep restarts; busy lasts a further
//     256 cycles after reset deasserts.

Source files
------------

// File: rtl/cam_match_array_if.sv
// Write, search and status signals between the CAM storage/compare stage and its user.
// The master side drives writes, searches and flushes; the slave side is the match array.
interface cam_match_array_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = (1 << ADDR_WIDTH),
    parameter int DATA_WIDTH = 16
);
    logic                  flush_req;
    logic                  wr_enable;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  search_enable;
    logic [DATA_WIDTH-1:0] search_data;
    logic [DEPTH-1:0]      match_lines;
    logic                  match_valid;
    logic                  busy;
    logic [ADDR_WIDTH:0]   entry_count;

    modport master (
        output flush_req, wr_enable, wr_addr, wr_data, wr_valid, search_enable, search_data,
        input  match_lines, match_valid, busy, entry_count
    );

    modport slave (
        input  flush_req, wr_enable, wr_addr, wr_data, wr_valid, search_enable, search_data,
        output match_lines, match_valid, busy, entry_count
    );
endinterface

// File: rtl/cam_match_array.sv
// CAM storage and parallel compare stage; produces a registered match vector for the
// downstream priority encoder. A sweep FSM clears every entry after reset or on flush.
module cam_match_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = (1 << ADDR_WIDTH),
    parameter int DATA_WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    cam_match_array_if.slave  bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      valid_bits;
    logic [DEPTH-1:0]      hit;
    logic                  start_flush;
    logic                  do_write;
    logic                  do_search;

    // A flush request in IDLE pre-empts any write or search presented with it.
    always_comb begin
        next_state  = state;
        start_flush = 1'b0;
        do_write    = 1'b0;
        do_search   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush_req) begin
                    next_state  = FLUSH;
                    start_flush = 1'b1;
                end else begin
                    do_write  = bus.wr_enable;
                    do_search = bus.search_enable;
                end
            end
            FLUSH: begin
                if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FLUSH;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (start_flush) begin
                ptr <= '0;
            end else if (state == FLUSH) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Storage has no reset network; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FLUSH) begin
                data_mem[ptr]   <= '0;
                valid_bits[ptr] <= 1'b0;
            end else if (do_write) begin
                valid_bits[bus.wr_addr] <= bus.wr_valid;
                if (bus.wr_valid) begin
                    data_mem[bus.wr_addr] <= bus.wr_data;
                end
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_bits[i] && (data_mem[i] == bus.search_data);
        end
    end

    // Compare sees pre-write contents, so a same-cycle write is visible one search later.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.match_lines <= '0;
            bus.match_valid <= 1'b0;
            bus.entry_count <= '0;
        end else begin
            bus.match_valid <= do_search;
            bus.match_lines <= do_search ? hit : '0;
            if (start_flush) begin
                bus.entry_count <= '0;
            end else if (do_write) begin
                if (bus.wr_valid && !valid_bits[bus.wr_addr]) begin
                    bus.entry_count <= bus.entry_count + 1'b1;
                end else if (!bus.wr_valid && valid_bits[bus.wr_addr]) begin
                    bus.entry_count <= bus.entry_count - 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == FLUSH);
endmodule

// File: tb/tb_cam_match_array.sv
// Directed bench for cam_match_array: reset sweep, write/search/invalidate, same-cycle
// write+search ordering, full fill, flush with dropped traffic, and reset mid-sweep.
module tb_cam_match_array;
    logic clk;
    logic reset;
    int   check_count;
    int   pass_count;
    int   n;
    logic mv_seen;
    logic [255:0] exp_lines;

    cam_match_array_if #(.ADDR_WIDTH(8), .DEPTH(256), .DATA_WIDTH(16)) bus ();

    cam_match_array #(.ADDR_WIDTH(8), .DEPTH(256), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle of traffic, then all strobes drop back to idle.
    task automatic applyStimulus(input logic flush, input logic wr_en, input logic [7:0] addr,
                                 input logic [15:0] data, input logic wr_v, input logic s_en,
                                 input logic [15:0] key);
        bus.flush_req     = flush;
        bus.wr_enable     = wr_en;
        bus.wr_addr       = addr;
        bus.wr_data       = data;
        bus.wr_valid      = wr_v;
        bus.search_enable = s_en;
        bus.search_data   = key;
        step();
        bus.flush_req     = 1'b0;
        bus.wr_enable     = 1'b0;
        bus.search_enable = 1'b0;
    endtask

    initial begin
        check_count       = 0;
        pass_count        = 0;
        reset             = 1'b1;
        bus.flush_req     = 1'b0;
        bus.wr_enable     = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.wr_valid      = 1'b0;
        bus.search_enable = 1'b0;
        bus.search_data   = '0;

        // 1: reset sweep
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_count", 256'(bus.entry_count), 256'd0);
        checkOutput("rst_mv", 256'(bus.match_valid), 256'd0);
        n = 0;
        mv_seen = 1'b0;
        while (bus.busy && n < 1000) begin
            n++;
            mv_seen |= bus.match_valid;
            step();
        end
        checkOutput("rst_busy_cycles", 256'(n), 256'd256);
        checkOutput("rst_mv_during_sweep", 256'(mv_seen), 256'd0);
        checkOutput("rst_count_after", 256'(bus.entry_count), 256'd0);

        // 2: two BEEF entries and one other
        applyStimulus(1'b0, 1'b1, 8'd3,   16'hBEEF, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 8'd200, 16'hBEEF, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 8'd7,   16'h1234, 1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'hBEEF);
        exp_lines = '0;
        exp_lines[3] = 1'b1;
        exp_lines[200] = 1'b1;
        checkOutput("t2_mv", 256'(bus.match_valid), 256'd1);
        checkOutput("t2_lines", bus.match_lines, exp_lines);
        checkOutput("t2_count", 256'(bus.entry_count), 256'd3);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 16'hBEEF);
        checkOutput("t2_idle_mv", 256'(bus.match_valid), 256'd0);
        checkOutput("t2_idle_lines", bus.match_lines, 256'd0);

        // 3: invalidate, overwrite
        applyStimulus(1'b0, 1'b1, 8'd3, 16'h0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        exp_lines = '0;
        exp_lines[200] = 1'b1;
        checkOutput("t3_lines", bus.match_lines, exp_lines);
        checkOutput("t3_count", 256'(bus.entry_count), 256'd2);
        applyStimulus(1'b0, 1'b1, 8'd200, 16'h0001, 1'b1, 1'b0, 16'h0);
        checkOutput("t3_overwrite_count", 256'(bus.entry_count), 256'd2);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'h0001);
        checkOutput("t3_new_data_lines", bus.match_lines, exp_lines);
        applyStimulus(1'b0, 1'b1, 8'd3, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("t3_reinvalidate_count", 256'(bus.entry_count), 256'd2);

        // 4: write and search in the same cycle
        applyStimulus(1'b0, 1'b1, 8'd9, 16'hCAFE, 1'b1, 1'b1, 16'hCAFE);
        checkOutput("t4_same_mv", 256'(bus.match_valid), 256'd1);
        checkOutput("t4_same_lines", bus.match_lines, 256'd0);
        checkOutput("t4_count", 256'(bus.entry_count), 256'd3);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'hCAFE);
        exp_lines = '0;
        exp_lines[9] = 1'b1;
        checkOutput("t4_next_lines", bus.match_lines, exp_lines);

        // 5: fill every entry, then flush with traffic attached
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 16'(i), 1'b1, 1'b0, 16'h0);
        end
        checkOutput("t5_full_count", 256'(bus.entry_count), 256'd256);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'h0005);
        exp_lines = '0;
        exp_lines[5] = 1'b1;
        checkOutput("t5_full_lines", bus.match_lines, exp_lines);
        applyStimulus(1'b1, 1'b1, 8'd5, 16'h0005, 1'b1, 1'b1, 16'h0005);
        checkOutput("t5_flush_mv", 256'(bus.match_valid), 256'd0);
        checkOutput("t5_flush_lines", bus.match_lines, 256'd0);
        checkOutput("t5_flush_count", 256'(bus.entry_count), 256'd0);
        n = 0;
        while (bus.busy && n < 1000) begin
            n++;
            bus.flush_req = (n == 50);
            step();
        end
        bus.flush_req = 1'b0;
        checkOutput("t5_busy_cycles", 256'(n), 256'd256);
        checkOutput("t5_count_after", 256'(bus.entry_count), 256'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'h0000);
        checkOutput("t5_zero_key_mv", 256'(bus.match_valid), 256'd1);
        checkOutput("t5_zero_key_lines", bus.match_lines, 256'd0);

        // 6: reset 100 cycles into a sweep, with a search in flight
        applyStimulus(1'b1, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k < 100; k++) begin
            step();
        end
        reset = 1'b1;
        bus.search_enable = 1'b1;
        step();
        reset = 1'b0;
        bus.search_enable = 1'b0;
        checkOutput("t6_reset_mv", 256'(bus.match_valid), 256'd0);
        n = 0;
        mv_seen = 1'b0;
        while (bus.busy && n < 1000) begin
            n++;
            mv_seen |= bus.match_valid;
            if (n == 200) begin
                bus.wr_enable     = 1'b1;
                bus.wr_addr       = 8'd10;
                bus.wr_data       = 16'hAAAA;
                bus.wr_valid      = 1'b1;
                bus.search_enable = 1'b1;
                bus.search_data   = 16'hAAAA;
            end
            step();
            bus.wr_enable     = 1'b0;
            bus.search_enable = 1'b0;
        end
        checkOutput("t6_busy_cycles", 256'(n), 256'd256);
        checkOutput("t6_mv_during_sweep", 256'(mv_seen), 256'd0);
        checkOutput("t6_count_after", 256'(bus.entry_count), 256'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'hAAAA);
        checkOutput("t6_busy_write_dropped", bus.match_lines, 256'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
